alu_op_sequencer: RTL and testbench

//  Front-end sequencer for the 8-bit ALU's shared tri-state result bus. It accepts one

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_onehot_decode.sv | 21 ++
 rtl/alu_op_sequencer.sv | 115 +++++++++++
 tb/tb_alu_op_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU front-end: opcodes, sequencer states, widths.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int OP_W      = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'd0;
  localparam logic [OP_W-1:0] OP_OR  = 3'd1;
  localparam logic [OP_W-1:0] OP_ADD = 3'd2;
  localparam logic [OP_W-1:0] OP_SUB = 3'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

endpackage

// File: rtl/alu_onehot_decode.sv
// Opcode to one-hot tri-state enable decoder; all-zero unless en_in is set.
module alu_onehot_decode
  import alu_pkg::*;
#(
  parameter int NUM_UNITS = 4
) (
  input  logic [OP_W-1:0]      op,
  input  logic                 en_in,
  output logic [NUM_UNITS-1:0] unit_en
);

  // Each bit compares against its own index, so more than one bit can never be set.
  always_comb begin
    // NOTE: assign every combinational output a default first so no path infers a latch.
    unit_en = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      unit_en[i] = en_in && (op == OP_W'(i));
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Request/response sequencer that owns the shared ALU result bus: registers operands,
// enables one unit for the settle window, captures the bus and returns result plus flags.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int NUM_UNITS     = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  input  logic [OP_W-1:0]      req_op,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic [NUM_UNITS-1:0] unit_en,
  input  logic [WIDTH:0]       alu_bus,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH:0]       rsp_result,
  output logic                 rsp_zero,
  output logic                 rsp_carry,
  output logic                 rsp_err
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t          state, state_next;
  logic [OP_W-1:0] op_q;
  logic [CNT_W-1:0] cnt;
  logic            accept, capture, op_legal;

  assign op_legal  = int'(req_op) < NUM_UNITS;
  assign req_ready = rst_n && (state == IDLE);
  assign rsp_valid = (state == RESPOND);

  // NOTE: state lives in always_ff with non-blocking assignments; the async reset forces IDLE
  // the instant rst_n falls, which is what takes unit_en and rsp_valid low without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = op_legal ? DRIVE : RESPOND;
        end
      end
      DRIVE: begin
        if (cnt == CNT_LAST) begin
          capture    = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operands and response are only written on accept/capture, so they hold through RESPOND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_q       <= '0;
      cnt        <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      op_a <= req_a;
      op_b <= req_b;
      op_q <= req_op;
      cnt  <= '0;
      if (op_legal) begin
        rsp_err <= 1'b0;
      end else begin
        rsp_err    <= 1'b1;
        rsp_result <= '0;
        rsp_zero   <= 1'b1;
        rsp_carry  <= 1'b0;
      end
    end else if (capture) begin
      rsp_result <= alu_bus;
      rsp_zero   <= (alu_bus[WIDTH-1:0] == '0);
      rsp_carry  <= alu_bus[WIDTH];
    end else if (state == DRIVE) begin
      cnt <= cnt + 1'b1;
    end
  end

  alu_onehot_decode #(.NUM_UNITS(NUM_UNITS)) u_decode (
    .op      (op_q),
    .en_in   (state == DRIVE),
    .unit_en (unit_en)
  );

  a_en_onehot:   assert property (@(posedge clk) $onehot0(unit_en));
  a_en_in_drive: assert property (@(posedge clk) (state != DRIVE) |-> (unit_en == '0));
  a_en_reset:    assert property (@(posedge clk) !rst_n |-> (unit_en == '0));

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: settle=1 instance for handshake/flag/reset cases, settle=3 for back-to-back ops.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // settle=1 instance
  logic       req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b0;
  logic [7:0] req_a = '0, req_b = '0, op_a, op_b;
  logic [2:0] req_op = '0;
  logic [3:0] unit_en;
  logic [8:0] bus_val = '0, alu_bus, rsp_result;
  logic       rsp_zero, rsp_carry, rsp_err;

  // The bus floats to a junk pattern whenever no unit drives it.
  assign alu_bus = (|unit_en) ? bus_val : 9'h155;

  alu_op_sequencer #(.WIDTH(8), .NUM_UNITS(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .op_a(op_a), .op_b(op_b), .unit_en(unit_en), .alu_bus(alu_bus),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
  );

  // settle=3 instance
  logic       req_valid3 = 1'b0, req_ready3, rsp_valid3, rsp_ready3 = 1'b1;
  logic [7:0] req_a3 = '0, req_b3 = '0, op_a3, op_b3;
  logic [2:0] req_op3 = '0;
  logic [3:0] unit_en3;
  logic [8:0] bus3 = 9'h0AA, rsp_result3;
  logic       rsp_zero3, rsp_carry3, rsp_err3;

  alu_op_sequencer #(.WIDTH(8), .NUM_UNITS(4), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid3), .req_ready(req_ready3),
    .req_a(req_a3), .req_b(req_b3), .req_op(req_op3),
    .op_a(op_a3), .op_b(op_b3), .unit_en(unit_en3), .alu_bus(bus3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3),
    .rsp_zero(rsp_zero3), .rsp_carry(rsp_carry3), .rsp_err(rsp_err3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ops3 [3];
    logic [7:0] a3   [3];
    logic [7:0] b3   [3];
    logic [8:0] res3 [3];
    ops3 = '{OP_AND, OP_OR, OP_SUB};
    a3   = '{8'h0F, 8'h0F, 8'h05};
    b3   = '{8'h3C, 8'h30, 8'h06};
    res3 = '{9'h00C, 9'h03F, 9'h1FF};

    // Reset state
    #3;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_unit_en",   32'(unit_en), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_result", 32'(rsp_result), 0);
    check("rst_flags", 32'({rsp_zero, rsp_carry, rsp_err}), 0);
    check("rst_op_ab", 32'({op_a, op_b}), 0);
    check("rst_unit_en3", 32'(unit_en3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_req_ready", 32'(req_ready), 1);

    // 1. AND
    req_valid = 1'b1; req_a = 8'hF0; req_b = 8'h3C; req_op = OP_AND; bus_val = 9'h030;
    step();
    check("and_unit_en", 32'(unit_en), 'b0001);
    check("and_op_a", 32'(op_a), 'hF0);
    check("and_op_b", 32'(op_b), 'h3C);
    check("and_busy", 32'({req_ready, rsp_valid}), 0);
    req_valid = 1'b0;
    step();
    check("and_en_off", 32'(unit_en), 0);
    check("and_valid", 32'(rsp_valid), 1);
    check("and_result", 32'(rsp_result), 'h030);
    check("and_flags", 32'({rsp_zero, rsp_carry, rsp_err}), 0);
    rsp_ready = 1'b1;
    step();
    check("and_done", 32'({req_ready, rsp_valid}), 'b10);
    rsp_ready = 1'b0;

    // 2. ADD with carry and zero
    req_valid = 1'b1; req_a = 8'hFF; req_b = 8'h01; req_op = OP_ADD; bus_val = 9'h100;
    step();
    check("add_unit_en", 32'(unit_en), 'b0100);
    req_valid = 1'b0;
    step();
    check("add_result", 32'(rsp_result), 'h100);
    check("add_flags", 32'({rsp_zero, rsp_carry, rsp_err}), 'b110);

    // 3. Backpressure; a new request waiting meanwhile must be ignored
    req_valid = 1'b1; req_a = 8'h12; req_b = 8'h34; req_op = OP_OR; bus_val = 9'h036;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_result", 32'(rsp_result), 'h100);
      check("bp_flags", 32'({rsp_zero, rsp_carry, rsp_err}), 'b110);
      check("bp_ready_en", 32'({req_ready, unit_en}), 0);
      check("bp_op_a", 32'(op_a), 'hFF);
      if (i < 4) step();
    end
    rsp_ready = 1'b1;
    step();
    check("bp_handshake", 32'({req_ready, rsp_valid}), 'b10);
    step();
    check("bp_resume_en", 32'(unit_en), 'b0010);
    check("bp_resume_op", 32'({op_a, op_b}), 'h1234);
    req_valid = 1'b0;
    step();
    check("or_result", 32'(rsp_result), 'h036);
    check("or_valid", 32'(rsp_valid), 1);
    step();
    check("or_done", 32'(rsp_valid), 0);

    // 4. Illegal opcode (rsp_ready still high: handshake on the next edge)
    req_valid = 1'b1; req_a = 8'hAA; req_b = 8'h55; req_op = 3'd5; bus_val = 9'h0FF;
    step();
    check("ill_unit_en", 32'(unit_en), 0);
    check("ill_valid", 32'(rsp_valid), 1);
    check("ill_err", 32'(rsp_err), 1);
    check("ill_result", 32'(rsp_result), 0);
    check("ill_zero_carry", 32'({rsp_zero, rsp_carry}), 'b10);
    req_valid = 1'b0;
    step();
    check("ill_done", 32'({req_ready, rsp_valid, unit_en}), 'b100000);
    rsp_ready = 1'b0;

    // 5. Reset in the middle of DRIVE
    req_valid = 1'b1; req_a = 8'h10; req_b = 8'h01; req_op = OP_SUB; bus_val = 9'h00F;
    step();
    check("mid_unit_en", 32'(unit_en), 'b1000);
    check("mid_err_clear", 32'(rsp_err), 0);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    check("mid_rst_en", 32'(unit_en), 0);
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", 32'(req_ready), 1);
    step();
    check("mid_no_stale", 32'({rsp_valid, unit_en, rsp_result}), 0);

    // 6. Settle=3, back-to-back ops with rsp_ready held high
    for (int k = 0; k < 3; k++) begin
      check("s3_ready", 32'(req_ready3), 1);
      req_valid3 = 1'b1; req_op3 = ops3[k]; req_a3 = a3[k]; req_b3 = b3[k];
      for (int c = 0; c < 3; c++) begin
        step();
        check("s3_unit_en", 32'(unit_en3), 32'(1) << ops3[k]);
        check("s3_not_valid", 32'(rsp_valid3), 0);
        req_valid3 = 1'b0;
        bus3 = (c == 2) ? res3[k] : 9'(9'h0A0 + c);
      end
      step();
      check("s3_en_off", 32'(unit_en3), 0);
      check("s3_valid", 32'(rsp_valid3), 1);
      check("s3_result", 32'(rsp_result3), 32'(res3[k]));
      check("s3_carry", 32'(rsp_carry3), 32'(res3[k][8]));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
